// File: rtl/aes_round_ctrl.sv
// AES round sequencer: accepts a block, issues NR round-advance strobes with
// the key-expansion round constant, then holds the result until it is taken.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | no block in flight; ready to accept
// S_ROUND | datapath advancing one round per cycle, round_num = 1..NR
// S_DONE  | ciphertext final, waiting for out_ready (or back-to-back accept)
module aes_round_ctrl #(
    parameter int NR = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       abort,
    input  logic       out_ready,
    output logic       out_valid,
    output logic       ld_init,
    output logic       rnd_en,
    output logic       mix_bypass,
    output logic [3:0] round_num,
    output logic [7:0] rcon,
    output logic       busy
);

    localparam logic [3:0] NR_L = 4'(NR);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ROUND = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic [3:0] left_q, left_d;
    logic [7:0] rcon_q, rcon_d;
    logic       accept;

    function automatic logic [7:0] mul2(input logic [7:0] r);
        return {r[6:0], 1'b0} ^ (r[7] ? 8'h1B : 8'h00);
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            left_q  <= '0;
            rcon_q  <= '0;
        end else begin
            state_q <= state_d;
            left_q  <= left_d;
            rcon_q  <= rcon_d;
        end
    end

    // left_q is a down-counter of rounds remaining after the current one;
    // the last round is its terminal count of zero.
    always_comb begin
        state_d    = state_q;
        left_d     = left_q;
        rcon_d     = rcon_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        rnd_en     = 1'b0;
        mix_bypass = 1'b0;
        round_num  = '0;
        rcon       = '0;
        busy       = 1'b0;

        case (state_q)
            S_IDLE: begin
                in_ready = !rst;
            end
            S_ROUND: begin
                busy       = 1'b1;
                rnd_en     = 1'b1;
                round_num  = NR_L - left_q;
                mix_bypass = (left_q == 4'd0);
                rcon       = rcon_q;
                if (left_q == 4'd0) begin
                    state_d = S_DONE;
                end else begin
                    left_d = left_q - 4'd1;
                    rcon_d = mul2(rcon_q);
                end
            end
            S_DONE: begin
                busy      = 1'b1;
                out_valid = !abort;
                in_ready  = out_ready && !rst;
                if (out_ready) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        accept  = in_valid && in_ready && !abort;
        ld_init = accept;

        if (abort && state_q != S_IDLE) state_d = S_IDLE;

        if (accept) begin
            state_d = S_ROUND;
            left_d  = NR_L - 4'd1;
            rcon_d  = 8'h01;
        end

        // Reset masks every output so a discarded block never shows as valid.
        if (rst) begin
            out_valid  = 1'b0;
            rnd_en     = 1'b0;
            mix_bypass = 1'b0;
            round_num  = '0;
            rcon       = '0;
            busy       = 1'b0;
            ld_init    = 1'b0;
        end
    end

endmodule
